// File: rtl/bu_sched.sv
// ----------------------------------------------------------------------------
// bu_sched -- address and control sequencer for the NTT butterfly datapath.
//
// Runs the full LOG_N-stage loop nest for a forward Cooley-Tukey (CT) or
// inverse Gentleman-Sande (GS) transform. Issues one butterfly per cycle:
// u/t coefficient read addresses plus the twiddle index k. The same u/t
// addresses come back out as write-back addresses MEM_LAT+BU_LAT cycles
// later. Between stages the sequencer drains for that same latency so a
// stage never reads a location the previous stage has not written yet.
//
// Optional feature macro: BU_SCHED_STALL_EN
//   defined   -> stall_i port exists; stall_i=1 in ISSUE holds issue.
//   undefined -> no stall_i port; issue is never paused.
//
// Parameters
//   LOG_N    log2 of transform size N (N/2 butterflies per stage)
//   MEM_LAT  coefficient/twiddle memory read latency
//   BU_LAT   butterfly latency
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       start request, sampled only in IDLE
//   ct_ngs_i      mode (1 = CT, 0 = GS), latched with start_i
//   stall_i       issue hold (BU_SCHED_STALL_EN only)
//   busy_o        transform in progress
//   done_o        one-cycle completion pulse
//   bu_ct_ngs_o   latched mode to the butterfly
//   rd_en_o       read strobe
//   rd_addr_u_o   u read address
//   rd_addr_t_o   t read address
//   tw_addr_o     twiddle index k
//   wr_en_o       write-back strobe
//   wr_addr_u_o   u write-back address
//   wr_addr_t_o   t write-back address
// ----------------------------------------------------------------------------
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | waiting for start_i; all strobes low
// ISSUE  | one butterfly per cycle for the current stage
// DRAIN  | waiting out the read+butterfly latency before the next stage
// ----------------------------------------------------------------------------
module bu_sched #(
    parameter int LOG_N   = 8,
    parameter int MEM_LAT = 1,
    parameter int BU_LAT  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             ct_ngs_i,
`ifdef BU_SCHED_STALL_EN
    input  logic             stall_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             bu_ct_ngs_o,
    output logic             rd_en_o,
    output logic [LOG_N-1:0] rd_addr_u_o,
    output logic [LOG_N-1:0] rd_addr_t_o,
    output logic [LOG_N-1:0] tw_addr_o,
    output logic             wr_en_o,
    output logic [LOG_N-1:0] wr_addr_u_o,
    output logic [LOG_N-1:0] wr_addr_t_o
);

    localparam int LAT = MEM_LAT + BU_LAT;
    localparam int DW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef logic [LOG_N-1:0] idx_t;

    localparam idx_t ONE      = idx_t'(1);
    localparam idx_t LOG_N_M1 = idx_t'(LOG_N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    idx_t          stage_q;
    idx_t          base_q;
    idx_t          off_q;
    idx_t          k_q;
    logic [DW-1:0] drain_q;

    logic stall_w;
`ifdef BU_SCHED_STALL_EN
    assign stall_w = stall_i;
`else
    assign stall_w = 1'b0;
`endif

    // Half-span of a butterfly in a given stage: CT halves it each stage,
    // GS doubles it.
    function automatic idx_t len_of(input idx_t stage_v, input logic ct);
        if (ct) begin
            return ONE << (LOG_N_M1 - stage_v);
        end
        return ONE << stage_v;
    endfunction

    idx_t len_cur;
    idx_t len_first;
    idx_t len_next;
    idx_t k_init;
    idx_t k_step;
    idx_t base_adv;
    idx_t base_nx;
    idx_t off_nx;
    idx_t k_nx;
    idx_t u_nx;
    idx_t t_nx;
    logic off_last;
    logic stage_end;
    logic last_stage;

    // The counters hold the butterfly most recently issued; this block
    // derives the one that follows it.
    always_comb begin
        len_cur    = len_of(stage_q, bu_ct_ngs_o);
        len_first  = len_of('0, ct_ngs_i);
        len_next   = len_of(stage_q + ONE, bu_ct_ngs_o);
        k_init     = ct_ngs_i ? ONE : '1;
        k_step     = bu_ct_ngs_o ? (k_q + ONE) : (k_q - ONE);
        off_last   = (off_q == (len_cur - ONE));
        // Group base wraps to 0 at N, which marks the end of the stage.
        base_adv   = base_q + (len_cur << 1);
        stage_end  = off_last && (base_adv == '0);
        last_stage = (stage_q == LOG_N_M1);
        if (off_last) begin
            base_nx = base_adv;
            off_nx  = '0;
            k_nx    = k_step;
        end else begin
            base_nx = base_q;
            off_nx  = off_q + ONE;
            k_nx    = k_q;
        end
        u_nx = base_nx + off_nx;
        t_nx = u_nx + len_cur;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            base_q      <= '0;
            off_q       <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            bu_ct_ngs_o <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_u_o <= '0;
            rd_addr_t_o <= '0;
            tw_addr_o   <= '0;
        end else begin
            done_o      <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_u_o <= '0;
            rd_addr_t_o <= '0;
            tw_addr_o   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_ISSUE;
                        busy_o      <= 1'b1;
                        bu_ct_ngs_o <= ct_ngs_i;
                        stage_q     <= '0;
                        base_q      <= '0;
                        off_q       <= '0;
                        k_q         <= k_init;
                        rd_en_o     <= 1'b1;
                        rd_addr_u_o <= '0;
                        rd_addr_t_o <= len_first;
                        tw_addr_o   <= k_init;
                    end
                end
                S_ISSUE: begin
                    if (stall_w) begin
                        // hold all counters; rd_en_o stays low this cycle
                    end else if (stage_end) begin
                        state_q <= S_DRAIN;
                        drain_q <= DW'(LAT - 1);
                        base_q  <= '0;
                        off_q   <= '0;
                        k_q     <= k_step;
                    end else begin
                        base_q      <= base_nx;
                        off_q       <= off_nx;
                        k_q         <= k_nx;
                        rd_en_o     <= 1'b1;
                        rd_addr_u_o <= u_nx;
                        rd_addr_t_o <= t_nx;
                        tw_addr_o   <= k_nx;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        if (last_stage) begin
                            state_q <= S_IDLE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            state_q     <= S_ISSUE;
                            stage_q     <= stage_q + ONE;
                            rd_en_o     <= 1'b1;
                            rd_addr_u_o <= '0;
                            rd_addr_t_o <= len_next;
                            tw_addr_o   <= k_q;
                        end
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Write-back delay line: samples the registered read outputs, so the
    // last tap reproduces them exactly LAT cycles later. Runs every cycle.
    logic sr_v [LAT];
    idx_t sr_u [LAT];
    idx_t sr_t [LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                sr_v[i] <= 1'b0;
                sr_u[i] <= '0;
                sr_t[i] <= '0;
            end
        end else begin
            sr_v[0] <= rd_en_o;
            sr_u[0] <= rd_addr_u_o;
            sr_t[0] <= rd_addr_t_o;
            for (int i = 1; i < LAT; i++) begin
                sr_v[i] <= sr_v[i-1];
                sr_u[i] <= sr_u[i-1];
                sr_t[i] <= sr_t[i-1];
            end
        end
    end

    assign wr_en_o     = sr_v[LAT-1];
    assign wr_addr_u_o = sr_u[LAT-1];
    assign wr_addr_t_o = sr_t[LAT-1];

endmodule

// File: tb/tb_bu_sched.sv
module tb_bu_sched;

    localparam int LOG_N = 3;

    logic             clk_i;
    logic             rst_ni;
    logic             start_i;
    logic             ct_ngs_i;
    logic             stall_i;
    logic             busy_o;
    logic             done_o;
    logic             bu_ct_ngs_o;
    logic             rd_en_o;
    logic [LOG_N-1:0] rd_addr_u_o;
    logic [LOG_N-1:0] rd_addr_t_o;
    logic [LOG_N-1:0] tw_addr_o;
    logic             wr_en_o;
    logic [LOG_N-1:0] wr_addr_u_o;
    logic [LOG_N-1:0] wr_addr_t_o;

    int vectors;
    int miscompares;

    bu_sched #(.LOG_N(LOG_N), .MEM_LAT(1), .BU_LAT(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .ct_ngs_i    (ct_ngs_i),
`ifdef BU_SCHED_STALL_EN
        .stall_i     (stall_i),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bu_ct_ngs_o (bu_ct_ngs_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_u_o (rd_addr_u_o),
        .rd_addr_t_o (rd_addr_t_o),
        .tw_addr_o   (tw_addr_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_u_o (wr_addr_u_o),
        .wr_addr_t_o (wr_addr_t_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hand-derived butterfly sequences for N=8.
    int ct_u [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int ct_t [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int ct_k [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
    int gs_u [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int gs_t [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int gs_k [12] = '{7, 6, 5, 4, 3, 3, 2, 2, 1, 1, 1, 1};

    task automatic chk(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Read cycle of butterfly i relative to the start edge: 4 issue + 3 drain
    // per stage; the stall scenario delays everything after the first read by 2.
    function automatic int rd_cyc(input int i, input bit stalled);
        return 1 + (i / 4) * 7 + (i % 4) + ((stalled && i >= 1) ? 2 : 0);
    endfunction

    task automatic chk_zero(input string tag, input int c);
        chk({tag, ".busy"},  c, busy_o,      0);
        chk({tag, ".done"},  c, done_o,      0);
        chk({tag, ".mode"},  c, bu_ct_ngs_o, 0);
        chk({tag, ".rd_en"}, c, rd_en_o,     0);
        chk({tag, ".rd_u"},  c, rd_addr_u_o, 0);
        chk({tag, ".rd_t"},  c, rd_addr_t_o, 0);
        chk({tag, ".tw"},    c, tw_addr_o,   0);
        chk({tag, ".wr_en"}, c, wr_en_o,     0);
        chk({tag, ".wr_u"},  c, wr_addr_u_o, 0);
        chk({tag, ".wr_t"},  c, wr_addr_t_o, 0);
    endtask

    // Caller raises start_i in an idle cycle; this steps through the run and
    // checks every cycle up to the done pulse (or up to abort_cyc).
    task automatic run_chk(input bit ct, input bit stalled, input int pulse_cyc,
                           input bit hold_start, input int abort_cyc);
        int done_cyc;
        int ri;
        int wi;
        int eu;
        int et;
        int ek;
        done_cyc = stalled ? 24 : 22;
        for (int cyc = 1; cyc <= done_cyc; cyc++) begin
            step();
            ri = -1;
            wi = -1;
            for (int i = 0; i < 12; i++) begin
                if (rd_cyc(i, stalled) == cyc) ri = i;
                if (rd_cyc(i, stalled) + 3 == cyc) wi = i;
            end
            chk("busy", cyc, busy_o, (cyc < done_cyc) ? 1 : 0);
            chk("done", cyc, done_o, (cyc == done_cyc) ? 1 : 0);
            chk("mode", cyc, bu_ct_ngs_o, ct);
            chk("rd_en", cyc, rd_en_o, (ri >= 0) ? 1 : 0);
            if (ri >= 0) begin
                eu = ct ? ct_u[ri] : gs_u[ri];
                et = ct ? ct_t[ri] : gs_t[ri];
                ek = ct ? ct_k[ri] : gs_k[ri];
                chk("rd_u", cyc, rd_addr_u_o, eu);
                chk("rd_t", cyc, rd_addr_t_o, et);
                chk("tw",   cyc, tw_addr_o,   ek);
            end
            chk("wr_en", cyc, wr_en_o, (wi >= 0) ? 1 : 0);
            if (wi >= 0) begin
                eu = ct ? ct_u[wi] : gs_u[wi];
                et = ct ? ct_t[wi] : gs_t[wi];
                chk("wr_u", cyc, wr_addr_u_o, eu);
                chk("wr_t", cyc, wr_addr_t_o, et);
            end
            if (cyc == abort_cyc) return;
            if (!hold_start && cyc == 1) start_i = 1'b0;
            if (cyc == 2) ct_ngs_i = ~ct;
            if (cyc == pulse_cyc) start_i = 1'b1;
            if (cyc == pulse_cyc + 1) start_i = 1'b0;
            if (stalled && cyc == 1) stall_i = 1'b1;
            if (stalled && cyc == 3) stall_i = 1'b0;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        ct_ngs_i    = 1'b0;
        stall_i     = 1'b0;
        step();
        step();
        chk_zero("reset", 0);
        rst_ni = 1'b1;
        step();
        step();
        chk_zero("idle", 0);

        // CT run with a spurious start (and mode flip) at cycle 5.
        start_i  = 1'b1;
        ct_ngs_i = 1'b1;
        run_chk(1'b1, 1'b0, 5, 1'b0, -1);

        // Back-to-back: start accepted in the done cycle; GS with start held.
        start_i  = 1'b1;
        ct_ngs_i = 1'b0;
        run_chk(1'b0, 1'b0, -10, 1'b1, -1);

        // Start still high in the done cycle: a CT run follows at once,
        // then reset hits in cycle 10.
        ct_ngs_i = 1'b1;
        run_chk(1'b1, 1'b0, -10, 1'b0, 10);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_zero("async_rst", 10);
        step();
        step();
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk_zero("post_rst", c);
        end

`ifdef BU_SCHED_STALL_EN
        start_i  = 1'b1;
        ct_ngs_i = 1'b1;
        run_chk(1'b1, 1'b1, -10, 1'b0, -1);
        step();
        chk("stall_idle.busy", 25, busy_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bu_sched.md
# bu_sched

Address and control sequencer for the NTT butterfly datapath. Runs the complete LOG_N-stage forward (Cooley-Tukey) or inverse (Gentleman-Sande) transform loop nest. Each cycle it issues one butterfly's coefficient-memory read addresses and twiddle index, and drives the butterfly's CT/GS mode select. Matching write-back addresses come out after the fixed read-plus-butterfly latency; coefficient data flows memory→butterfly→memory and does not pass through this block.

## Interface
- LOG_N, 8, log2 of transform size N; N/2 butterflies per stage.
- MEM_LAT, 1, coefficient/twiddle memory read latency, cycles.
- BU_LAT, 2, butterfly latency (input register + output register), cycles.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- ct_ngs_i  in  1  mode: 1 = forward CT, 0 = inverse GS; latched with start_i.
- stall_i  in  1  issue hold (present only with BU_SCHED_STALL_EN).
- busy_o  out  1  transform in progress.
- done_o  out  1  one-cycle completion pulse.
- bu_ct_ngs_o  out  1  latched mode to the butterfly CT_nGS input.
- rd_en_o  out  1  read strobe, coefficient and twiddle memories.
- rd_addr_u_o, rd_addr_t_o  out  LOG_N  u / t coefficient read addresses.
- tw_addr_o  out  LOG_N  twiddle index k.
- wr_en_o  out  1  write-back strobe.
- wr_addr_u_o, wr_addr_t_o  out  LOG_N  u / t write-back addresses.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start_i=1 latches ct_ngs_i, clears the stage/group/index counters, and moves to ISSUE.
  - Initial k is 1 for CT and N-1 for GS.
- ISSUE: one butterfly per cycle (rd_en_o=1). stage s runs 0..LOG_N-1.
  - CT: len = N>>(s+1).
  - GS: len = 1<<s.
  - For each group base b = 0, 2len, 4len, … and each j = b..b+len-1: u = j, t = j+len, tw = k.
  - k steps after each group: +1 for CT, -1 for GS. Over the full transform k covers 1..N-1 exactly once.
- After the last butterfly of a stage, go to DRAIN. DRAIN waits LAT = MEM_LAT+BU_LAT cycles, so the next stage never reads a location the current stage has not yet written.
  - DRAIN leads to ISSUE of the next stage.
  - After the final stage, DRAIN leads to IDLE, with a done_o pulse.
- Write-back path:
  - The u/t addresses and a valid bit go through an LAT-deep shift register.
  - wr_en_o / wr_addr_*_o equal the rd values from LAT cycles earlier.
  - The shift register advances every cycle, including during stalls and DRAIN.
- start_i while busy_o=1 is ignored. ct_ngs_i is ignored outside the start cycle.
- bu_ct_ngs_o holds the latched mode until the next start.
- Counters are LOG_N-bit unsigned. Group base wraps to 0 at N, which ends the stage.

## Timing
- Reset (asynchronous, any state, including mid-transform):
  - State returns to IDLE and the shift register is cleared.
  - All outputs go to 0: busy_o, done_o, rd_en_o, wr_en_o, addresses, tw_addr_o, bu_ct_ngs_o.
  - The partial transform is abandoned.
- All outputs are registered.
- start_i is sampled high at edge 0 (cycle 0). Then:
  - busy_o=1 from cycle 1.
  - The first rd_en_o is in cycle 1.
  - The read issued in cycle c is written back in cycle c+LAT.
- Without stalls, one stage takes N/2 issue cycles plus LAT drain cycles.
  - The last write of the transform is in cycle LOG_N·(N/2+LAT).
  - done_o=1 and busy_o=0 in the following cycle.
- Back-to-back operation: start_i may be accepted in the cycle done_o is high. That is the first IDLE cycle.

## Configuration
- BU_SCHED_STALL_EN defined:
  - stall_i exists. stall_i=1 in ISSUE holds rd_en_o=0 and freezes all loop counters.
  - In-flight writes still complete on schedule.
  - stall_i has no effect in IDLE or DRAIN.
- BU_SCHED_STALL_EN undefined:
  - stall_i does not exist and issue is never paused.

## Test plan
- LOG_N=3, CT start at cycle 0 → the (u,t,k) sequence is exactly:
  - (0,4,1) (1,5,1) (2,6,1) (3,7,1)
  - (0,2,2) (1,3,2) (4,6,3) (5,7,3)
  - (0,1,4) (2,3,5) (4,5,6) (6,7,7)
  - rd_en_o in cycles 1–4, 8–11, 15–18; done_o at cycle 22.
- LOG_N=3, GS → the sequence is exactly:
  - (0,1,7) (2,3,6) (4,5,5) (6,7,4)
  - (0,2,3) (1,3,3) (4,6,2) (5,7,2)
  - (0,4,1)…(3,7,1)
  - bu_ct_ngs_o=0 throughout.
- Every rd at cycle c is matched by wr_en_o at c+3 with identical u/t addresses; no write occurs outside these cycles.
- start_i pulsed at cycle 5 of a running transform → no restart and identical addresses.
- start_i held high while done_o=1 → a second transform begins immediately.
- rst_ni low at cycle 10 → all outputs 0 asynchronously. After release with no start_i, the block stays in IDLE with outputs 0.
- With BU_SCHED_STALL_EN, stall_i=1 in cycles 2–3 → the remaining stage-0 reads move to cycles 4–6. The write for the cycle-1 read still occurs at cycle 4. done_o moves to cycle 24.
